// File: rtl/dmem_arbiter.sv
// Two-port (CPU / DMA) arbiter onto one synchronous-read data memory with burst limiting.
// Optional macro DMEM_ARB_RR_EN: round-robin tie-break from IDLE; when undefined, port 0 wins ties.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic          we0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic          we1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    state_t        state_q, state_d;
    logic [3:0]    burst_q, burst_d;
    logic          gnt0_c, gnt1_c;
    logic          tie_pick1;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_we_c;

`ifdef DMEM_ARB_RR_EN
    logic last1_q, last1_d;

    // last1_q marks port 1 as the most recent winner; ties go to the other port
    always_comb begin
        tie_pick1 = ~last1_q;
        last1_d   = last1_q;
        if (gnt1_c) begin
            last1_d = 1'b1;
        end else if (gnt0_c) begin
            last1_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last1_q <= 1'b1;
        end else begin
            last1_q <= last1_d;
        end
    end
`else
    always_comb begin
        tie_pick1 = 1'b0;
    end
`endif

    // Arbitration: the owner keeps the port until its burst quota is spent and the other side waits
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!reset) begin
            unique case (state_q)
                OWN0: begin
                    if (req0 && ((burst_q < BURST_MAX) || !req1)) begin
                        gnt0_c = 1'b1;
                    end else if (req1) begin
                        gnt1_c = 1'b1;
                    end
                end
                OWN1: begin
                    if (req1 && ((burst_q < BURST_MAX) || !req0)) begin
                        gnt1_c = 1'b1;
                    end else if (req0) begin
                        gnt0_c = 1'b1;
                    end
                end
                default: begin
                    if (req0 && req1) begin
                        gnt0_c = ~tie_pick1;
                        gnt1_c = tie_pick1;
                    end else begin
                        gnt0_c = req0;
                        gnt1_c = req1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        state_d = IDLE;
        burst_d = 4'd0;
        if (gnt0_c) begin
            state_d = OWN0;
            if (state_q == OWN0) begin
                burst_d = (burst_q >= BURST_MAX) ? BURST_MAX : burst_q + 4'd1;
            end else begin
                burst_d = 4'd1;
            end
        end else if (gnt1_c) begin
            state_d = OWN1;
            if (state_q == OWN1) begin
                burst_d = (burst_q >= BURST_MAX) ? BURST_MAX : burst_q + 4'd1;
            end else begin
                burst_d = 4'd1;
            end
        end
    end

    // Memory command mux; address and write data park on the last granted values
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_c    = 1'b0;
        if (gnt0_c) begin
            mem_addr_d  = addr0;
            mem_wdata_d = wdata0;
            mem_we_c    = we0;
        end else if (gnt1_c) begin
            mem_addr_d  = addr1;
            mem_wdata_d = wdata1;
            mem_we_c    = we1;
        end
    end

    always_comb begin
        rvalid0_d = gnt0_c & ~we0;
        rvalid1_d = gnt1_c & ~we1;
        rdata0_d  = rvalid0_q ? mem_rdata : rdata0_q;
        rdata1_d  = rvalid1_q ? mem_rdata : rdata1_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            burst_q     <= 4'd0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Outputs are forced to their idle values for as long as reset is held, including
    // a read response whose grant happened in the cycle just before reset rose.
    assign gnt0      = gnt0_c;
    assign gnt1      = gnt1_c;
    assign mem_we    = mem_we_c;
    assign mem_addr  = reset ? '0 : mem_addr_d;
    assign mem_wdata = reset ? '0 : mem_wdata_d;
    assign rvalid0   = rvalid0_q & ~reset;
    assign rvalid1   = rvalid1_q & ~reset;
    assign rdata0    = reset ? '0 : rdata0_d;
    assign rdata1    = reset ? '0 : rdata1_d;

    a_gnt_onehot: assert property (@(posedge clock) !(gnt0 && gnt1));
    a_no_gnt_in_reset: assert property (@(posedge clock) reset |-> !(gnt0 || gnt1));
    a_burst_range: assert property (@(posedge clock) burst_q <= BURST_MAX);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed grant expectations plus a queue of expected read returns.
module tb_dmem_arbiter;
    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0),
        .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        int            due;
    } rd_exp_t;

    rd_exp_t       sbq[$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    logic [DW-1:0] refm [0:255];
    logic [DW-1:0] mem  [0:255];
    logic          init_done = 1'b0;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wdata;

    function automatic logic [DW-1:0] pat(input int i);
        logic [31:0] v;
        v = i;
        return 32'hC0DE_0000 ^ (v * 32'h0001_0101);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous-read memory: data for a command appears one cycle later
    always @(posedge clock) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
            init_done <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[9:2]];
    end

    always @(negedge clock) begin : mon
        rd_exp_t e;
        if (sbq.size() != 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            chk("rvalid", {rvalid1, rvalid0}, e.port ? 2'b10 : 2'b01);
            chk(e.port ? "rdata1" : "rdata0", e.port ? rdata1 : rdata0, e.data);
        end else begin
            chk("rvalid_idle", {rvalid1, rvalid0}, 2'b00);
        end
    end

    task automatic set0(input logic r, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        req0 = r; addr0 = a; we0 = w; wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        req1 = r; addr1 = a; we1 = w; wdata1 = d;
    endtask

    task automatic step(input logic e0, input logic e1);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          w;
        @(negedge clock);
        chk("gnt0", gnt0, e0);
        chk("gnt1", gnt1, e1);
        if (e0 || e1) begin
            a = e1 ? addr1 : addr0;
            d = e1 ? wdata1 : wdata0;
            w = e1 ? we1 : we0;
            chk("mem_addr", mem_addr, a);
            chk("mem_we", mem_we, w);
            chk("mem_wdata", mem_wdata, d);
            last_addr  = a;
            last_wdata = d;
            if (w) refm[a[9:2]] = d;
            else sbq.push_back('{e1, refm[a[9:2]], cyc + 1});
        end else begin
            chk("mem_we_idle", mem_we, 1'b0);
            chk("mem_addr_hold", mem_addr, last_addr);
            chk("mem_wdata_hold", mem_wdata, last_wdata);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_outs();
        @(negedge clock);
        chk("rst_gnt", {gnt1, gnt0}, 2'b00);
        chk("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) refm[i] = pat(i);
        last_addr  = '0;
        last_wdata = '0;
        reset = 1'b1;
        set0(1'b1, 32'h40, 1'b0, 32'h0);
        set1(1'b1, 32'h44, 1'b0, 32'h0);
        @(posedge clock);
        #1;
        chk_reset_outs();
        chk_reset_outs();
        reset = 1'b0;

        // IDLE ties: first one after reset goes to port 0, the next depends on round robin
        step(1'b1, 1'b0);
        set0(1'b0, 32'h40, 1'b0, 32'h0);
        set1(1'b0, 32'h44, 1'b0, 32'h0);
        step(1'b0, 1'b0);
        set0(1'b1, 32'h48, 1'b0, 32'h0);
        set1(1'b1, 32'h4C, 1'b0, 32'h0);
`ifdef DMEM_ARB_RR_EN
        step(1'b0, 1'b1);
        set1(1'b0, 32'h4C, 1'b0, 32'h0);
        step(1'b1, 1'b0);
`else
        step(1'b1, 1'b0);
        set0(1'b0, 32'h48, 1'b0, 32'h0);
        step(1'b0, 1'b1);
`endif
        set0(1'b0, 32'h0, 1'b0, 32'h0);
        set1(1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0);

        // Port 0 write then read-back of the same word
        set0(1'b1, 32'h10, 1'b1, 32'h1234_5678);
        step(1'b1, 1'b0);
        set0(1'b1, 32'h10, 1'b0, 32'h0);
        step(1'b1, 1'b0);
        set0(1'b0, 32'h10, 1'b0, 32'h0);
        step(1'b0, 1'b0);

        // Port 0 read immediately followed by a port 1 write
        set0(1'b1, 32'h20, 1'b0, 32'h0);
        step(1'b1, 1'b0);
        set0(1'b0, 32'h20, 1'b0, 32'h0);
        set1(1'b1, 32'h24, 1'b1, 32'hDEAD_BEEF);
        step(1'b0, 1'b1);
        set1(1'b0, 32'h24, 1'b0, 32'h0);
        step(1'b0, 1'b0);

        // Both ports stream reads: bursts of MAX_BURST alternate
        set0(1'b1, 32'h30, 1'b0, 32'h0);
        set1(1'b1, 32'h34, 1'b0, 32'h0);
        for (int k = 0; k < 3 * MAX_BURST; k++) begin
            step(((k / MAX_BURST) % 2) == 0, ((k / MAX_BURST) % 2) == 1);
        end
        set0(1'b0, 32'h0, 1'b0, 32'h0);
        set1(1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0);

        // Port 1 alone for 10 cycles; the saturated count then yields to port 0 at once
        set1(1'b1, 32'h38, 1'b0, 32'h0);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1);
        set0(1'b1, 32'h3C, 1'b0, 32'h0);
        step(1'b1, 1'b0);
        set0(1'b0, 32'h3C, 1'b0, 32'h0);
        step(1'b0, 1'b1);
        set1(1'b0, 32'h38, 1'b0, 32'h0);
        step(1'b0, 1'b0);

        // Reset right after a port 1 read grant: its response is dropped
        set1(1'b1, 32'h50, 1'b0, 32'h0);
        step(1'b0, 1'b1);
        reset = 1'b1;
        sbq.delete();
        last_addr  = '0;
        last_wdata = '0;
        set0(1'b1, 32'h54, 1'b0, 32'h0);
        chk_reset_outs();
        chk_reset_outs();
        reset = 1'b0;
        step(1'b1, 1'b0);
        set0(1'b0, 32'h54, 1'b0, 32'h0);
        step(1'b0, 1'b1);
        set1(1'b0, 32'h50, 1'b0, 32'h0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        chk("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
